// File: rtl/regfile_scb.sv
// regfile_scb: parametrised integer register file for the pipelined NPC.
// NREAD combinational read ports, one writeback port, optional same-cycle
// write-to-read bypass, and a per-register pending-write scoreboard used by
// issue logic for RAW hazard detection. After reset an init sequencer walks
// the array and zeroes every entry before the block accepts operations.
module regfile_scb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    init_done,
  input  logic [NREAD*ADDR_W-1:0] raddr,
  output logic [NREAD*DATA_W-1:0] rdata,
  output logic [NREAD-1:0]        rbusy,
  input  logic                    iss_valid,
  input  logic [ADDR_W-1:0]       iss_addr,
  input  logic                    wen,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   icnt_q, icnt_d;
  logic                init_done_q, init_done_d;
  logic [DEPTH-1:0]    pending_q, pending_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_waddr_s;
  logic [DATA_W-1:0]   mem_wdata_s;
  logic                run_s;
  logic                wr_ok_s;
  logic                iss_ok_s;

  assign run_s    = (state_q == S_RUN);
  assign wr_ok_s  = run_s && wen && (waddr != ADDR_ZERO);
  assign iss_ok_s = run_s && iss_valid && (iss_addr != ADDR_ZERO);

  // Next-state for the init sequencer, done flag and pending scoreboard.
  always_comb begin
    state_d     = state_q;
    icnt_d      = icnt_q;
    init_done_d = init_done_q;
    pending_d   = pending_q;
    case (state_q)
      S_INIT: begin
        icnt_d = icnt_q + ADDR_ONE;
        if (icnt_q == ADDR_LAST) begin
          state_d     = S_RUN;
          init_done_d = 1'b1;
        end else begin
          state_d     = S_INIT;
        end
      end
      S_RUN: begin
        // A retiring write clears pending; a same-cycle issue to the same
        // register re-arms it because the new producer is still in flight.
        if (wr_ok_s) begin
          pending_d[waddr] = 1'b0;
        end else begin
          pending_d = pending_d;
        end
        if (iss_ok_s) begin
          pending_d[iss_addr] = 1'b1;
        end else begin
          pending_d = pending_d;
        end
      end
      default: begin
        state_d     = S_INIT;
        icnt_d      = ADDR_ONE;
        init_done_d = 1'b0;
        pending_d   = {DEPTH{1'b0}};
      end
    endcase
    pending_d[0] = 1'b0;
  end

  // Control state registers with synchronous reset restarting the init walk.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_INIT;
      icnt_q      <= ADDR_ONE;
      init_done_q <= 1'b0;
      pending_q   <= {DEPTH{1'b0}};
    end else begin
      state_q     <= state_d;
      icnt_q      <= icnt_d;
      init_done_q <= init_done_d;
      pending_q   <= pending_d;
    end
  end

  // Array write port select: init clearing walk or writeback.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = waddr;
    mem_wdata_s = wdata;
    if (reset) begin
      mem_we_s = 1'b0;
    end else if (state_q == S_INIT) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = icnt_q;
      mem_wdata_s = {DATA_W{1'b0}};
    end else begin
      mem_we_s    = wr_ok_s;
    end
  end

  // Register array storage; not reset, contents come from the init walk.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Combinational read ports with register-0 and optional bypass handling.
  always_comb begin
    rdata = {(NREAD*DATA_W){1'b0}};
    rbusy = {NREAD{1'b0}};
    for (int k = 0; k < NREAD; k++) begin
      if (!run_s || (raddr[k*ADDR_W +: ADDR_W] == ADDR_ZERO)) begin
        rdata[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        rbusy[k]                  = 1'b0;
      end else if ((BYPASS != 0) && wen && (waddr == raddr[k*ADDR_W +: ADDR_W])) begin
        rdata[k*DATA_W +: DATA_W] = wdata;
        rbusy[k]                  = 1'b0;
      end else begin
        rdata[k*DATA_W +: DATA_W] = mem_q[raddr[k*ADDR_W +: ADDR_W]];
        rbusy[k]                  = pending_q[raddr[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  assign init_done = init_done_q;

endmodule
